// File: rtl/mult_pkg.sv
// mult_pkg: operand/product widths and sequencer states shared by the multiplier arbiter.
package mult_pkg;
    localparam int OP_W = 8;
    localparam int PROD_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mult_rr_pick.sv
// mult_rr_pick: round-robin winner search starting just after the last served requester.
module mult_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               valid
);
    logic [IDX_W-1:0] j;
    always_comb begin
        win_oh = '0;
        win_idx = '0;
        j = '0;
        // lowest priority first, so the highest-priority hit is the one left standing
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(last_served) + k) % NUM_REQ);
            if (req[j]) begin
                win_oh = '0;
                win_oh[j] = 1'b1;
                win_idx = j;
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one start/done multiplier core among NUM_REQ clients with
// round-robin grant, registered operands, timeout guard and a one-cycle ack.
module mult_share_arb
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_a,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [OP_W*NUM_REQ-1:0] req_a,
    input  logic [OP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      ack,
    output logic [PROD_W-1:0]       result,
    output logic                    err,
    output logic                    busy,
    output logic                    mult_start,
    output logic [OP_W-1:0]         mult_dataa,
    output logic [OP_W-1:0]         mult_datab,
    input  logic                    mult_done,
    input  logic [PROD_W-1:0]       mult_product
);
    localparam int IDX_W = $clog2(NUM_REQ);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] last_served, win_q, pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic pick_valid, timeout;

    mult_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req(req),
        .last_served(last_served),
        .win_oh(pick_oh),
        .win_idx(pick_idx),
        .valid(pick_valid)
    );

    assign timeout = cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = pick_valid ? WAIT : IDLE;
            WAIT: state_nxt = (mult_done || timeout) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a)
        if (reset_a) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            gnt <= '0;
            ack <= '0;
            result <= '0;
            err <= 1'b0;
            busy <= 1'b0;
            mult_start <= 1'b0;
            mult_dataa <= '0;
            mult_datab <= '0;
            cnt <= '0;
            last_served <= IDX_W'(NUM_REQ - 1);
            win_q <= '0;
        end else begin
            mult_start <= 1'b0;
            ack <= '0;
            case (state)
                IDLE: if (pick_valid) begin
                    gnt <= pick_oh;
                    win_q <= pick_idx;
                    mult_dataa <= req_a[pick_idx*OP_W +: OP_W];
                    mult_datab <= req_b[pick_idx*OP_W +: OP_W];
                    mult_start <= 1'b1;
                    busy <= 1'b1;
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a done on the timeout edge still delivers the real product
                    if (mult_done || timeout) begin
                        result <= mult_done ? mult_product : '0;
                        err <= !mult_done;
                        ack <= gnt;
                    end
                end
                RESP: begin
                    gnt <= '0;
                    busy <= 1'b0;
                    last_served <= win_q;
                end
                default: ;
            endcase
        end
    end
endmodule
